coffee_dispense_ctrl: RTL
=========================

COFFEE_DISPENSE_CTRL -- requirements
Module: coffee_dispense_ctrl

Interface
REQ-001 Parameter BREW_CYCLES, default 8: clock cycles the brew valve stays open per cup (range 1..255).
REQ-002 Parameter ACK_TIMEOUT, default 16: maximum cycles to wait for a coin hopper acknowledge (range 1..255).
REQ-003 Port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port coffee, input, 1 bit: vend request from the upstream payment FSM.
REQ-006 Port balance, input, 2 bits: change owed, in 25ps coins (0..3), valid with coffee.
REQ-007 Port coin_ack, input, 1 bit: hopper acknowledges one ejected coin.
REQ-008 Port valve, output, 1 bit: brew valve open.
REQ-009 Port coin_eject, output, 1 bit: request to eject one 25ps coin.
REQ-010 Port busy, output, 1 bit: high in every state except IDLE.
REQ-011 Port done, output, 1 bit: one-cycle pulse when the vend completes.
REQ-012 Port change_left, output, 2 bits: coins still to be returned.
REQ-013 Port fault, output, 1 bit: sticky hopper-timeout flag.

Function
REQ-014 Register coffee each cycle as coffee_q. A vend trigger SHALL be coffee=1 and coffee_q=0 while in IDLE.
REQ-015 State machine states: IDLE, EJECT, WAIT_ACK, BREW, DONE. All outputs are registered.
REQ-016 On a trigger, load balance into change_left on the same edge. Next state is EJECT if balance≠0, otherwise BREW.
REQ-017 EJECT: assert coin_eject for exactly 1 cycle, then go to WAIT_ACK and clear the timeout counter.
REQ-018 WAIT_ACK on coin_ack=1: decrement change_left, then go to EJECT if the new value is ≠0, otherwise go to BREW.
REQ-019 WAIT_ACK without an ack for ACK_TIMEOUT cycles: set fault, clear change_left, go to BREW.
REQ-020 coin_ack outside WAIT_ACK SHALL be ignored.
REQ-021 BREW: valve=1 for exactly BREW_CYCLES consecutive cycles, then go to DONE.
REQ-022 DONE: done=1 for 1 cycle, then go to IDLE.
REQ-023 Triggers while busy=1 SHALL be dropped and not queued. coffee held high across the return to IDLE SHALL NOT re-trigger.
REQ-024 Latency with balance=0: valve rises 1 cycle after the trigger edge; done rises BREW_CYCLES+1 cycles after the trigger edge.
REQ-025 change_left never wraps; its decrement is gated at 0.
REQ-026 fault clears only on rst.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL enter IDLE and force outputs: valve=0, coin_eject=0, busy=0, done=0, change_left=0, fault=0, coffee_q=0.
REQ-028 Reset SHALL take precedence over every transition, including mid-EJECT, mid-WAIT_ACK and mid-BREW; any partial vend is abandoned.

Configuration
REQ-029 Macro CUP_DETECT_EN: when defined, add input port cup_present (1 bit).
REQ-030 With CUP_DETECT_EN defined:
- BREW entry waits until cup_present=1.
- While cup_present=0 in BREW, valve=0 and the brew counter holds.
- The valve SHALL still be open for a total of BREW_CYCLES cycles.
REQ-031 Without CUP_DETECT_EN: the cup_present port does not exist and BREW behaves as in REQ-021.

Verification
REQ-032 BREW_CYCLES=8; coffee pulse with balance=0:
- valve high for 8 cycles, coin_eject never high.
- done pulses once, 9 cycles after the trigger.
REQ-033 balance=3; coin_ack returned 2 cycles after each coin_eject:
- exactly 3 coin_eject pulses; change_left steps 3→2→1→0.
- then 8 valve cycles, then done; fault=0.
REQ-034 balance=2; coin_ack never asserted; ACK_TIMEOUT=16:
- one coin_eject, then fault=1 after 16 cycles and change_left=0.
- brew still completes; fault stays 1 until rst.
REQ-035 Second coffee pulse during BREW, and coffee held high for 3 cycles:
- exactly one vend; busy stays 1 throughout; no second vend after return to IDLE.
REQ-036 rst asserted on the 4th valve cycle:
- next edge: valve=0, busy=0, state IDLE, all outputs 0.
- a new coffee pulse then starts a full 8-cycle brew.
REQ-037 CUP_DETECT_EN defined; cup_present drops for 5 cycles mid-BREW:
- valve low during those 5 cycles; total valve-high cycles = 8.
- done delayed by 5 cycles.

Source files
------------

// File: rtl/coffee_dispense_ctrl.sv
// rtl/coffee_dispense_ctrl.sv - coffee vend sequencer: change return, brew valve timing, done pulse
//
// Purpose : On a rising edge of the vend request, returns the change owed one
//           25p coin at a time through the hopper handshake. It then opens the
//           brew valve for BREW_CYCLES cycles and pulses done.
//           A hopper that never acknowledges raises a sticky fault. The coins it
//           still owed are written off, and the brew still happens.
// Params  : BREW_CYCLES  valve-open cycles per cup (1..255)
//           ACK_TIMEOUT  cycles to wait for coin_ack per coin (1..255)
// Macro   : CUP_DETECT_EN adds cup_present; the valve only opens (and the brew
//           counter only advances) while a cup is present.
// Ports   : clk          rising-edge clock
//           rst          synchronous active-high reset
//           coffee       vend request (edge-triggered)
//           balance      coins owed, valid with coffee
//           coin_ack     hopper ejected one coin
//           cup_present  cup in place (CUP_DETECT_EN only)
//           valve        brew valve open
//           coin_eject   eject-one-coin request
//           busy         vend in progress
//           done         one-cycle vend-complete pulse
//           change_left  coins still to be returned
//           fault        sticky hopper timeout

module coffee_dispense_ctrl #(
    parameter int BREW_CYCLES = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coffee,
    input  logic [1:0] balance,
    input  logic       coin_ack,
`ifdef CUP_DETECT_EN
    input  logic       cup_present,
`endif
    output logic       valve,
    output logic       coin_eject,
    output logic       busy,
    output logic       done,
    output logic [1:0] change_left,
    output logic       fault
);

    typedef enum logic [2:0] {
        IDLE,
        EJECT,
        WAIT_ACK,
        BREW,
        DONE
    } state_t;

    localparam logic [7:0] BREW_N   = 8'(BREW_CYCLES);
    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

    state_t     state;
    logic       coffee_q;
    logic [7:0] brew_cnt;
    logic [7:0] ack_cnt;
    logic       cup_ok;

`ifdef CUP_DETECT_EN
    assign cup_ok = cup_present;
`else
    assign cup_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            coffee_q    <= 1'b0;
            brew_cnt    <= 8'd0;
            ack_cnt     <= 8'd0;
            valve       <= 1'b0;
            coin_eject  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            change_left <= 2'd0;
            fault       <= 1'b0;
        end else begin
            coffee_q <= coffee;
            case (state)
                IDLE: begin
                    // The edge detect also blocks a request held high across the return to IDLE.
                    if (coffee && !coffee_q) begin
                        change_left <= balance;
                        busy        <= 1'b1;
                        brew_cnt    <= 8'd0;
                        state       <= (balance != 2'd0) ? EJECT : BREW;
                    end
                end
                EJECT: begin
                    coin_eject <= 1'b1;
                    ack_cnt    <= 8'd0;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    coin_eject <= 1'b0;
                    if (coin_ack) begin
                        if (change_left != 2'd0) begin
                            change_left <= change_left - 2'd1;
                        end
                        // More than one coin owed before this ack means more to eject.
                        if (change_left > 2'd1) begin
                            state <= EJECT;
                        end else begin
                            brew_cnt <= 8'd0;
                            state    <= BREW;
                        end
                    end else if (ack_cnt == ACK_LAST) begin
                        fault       <= 1'b1;
                        change_left <= 2'd0;
                        brew_cnt    <= 8'd0;
                        state       <= BREW;
                    end else begin
                        ack_cnt <= ack_cnt + 8'd1;
                    end
                end
                BREW: begin
                    // The valve output lags the state by one cycle. The final count
                    // therefore closes the valve and raises done together.
                    if (brew_cnt == BREW_N) begin
                        valve <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cup_ok) begin
                        valve    <= 1'b1;
                        brew_cnt <= brew_cnt + 8'd1;
                    end else begin
                        valve <= 1'b0;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
